// File: rtl/imem_if.sv
// -----------------------------------------------------------------------------
// imem_if
// Fetch-side bus between the processor fetch stage (master) and the
// instruction memory responder (slave).
//   proc2Imem_req   : fetch request valid                 (master -> slave)
//   proc2Imem_addr  : fetch byte address, bits [1:0] unused (master -> slave)
//   Imem_ready      : responder accepts fetch requests    (slave -> master)
//   Imem2proc_data  : returned instruction word           (slave -> master)
//   Imem2proc_valid : Imem2proc_data is a live response   (slave -> master)
//   Imem2proc_err   : response address was out of range   (slave -> master)
// -----------------------------------------------------------------------------
interface imem_if;
    logic        proc2Imem_req;
    logic [31:0] proc2Imem_addr;
    logic        Imem_ready;
    logic [31:0] Imem2proc_data;
    logic        Imem2proc_valid;
    logic        Imem2proc_err;

    modport master (
        output proc2Imem_req,
        output proc2Imem_addr,
        input  Imem_ready,
        input  Imem2proc_data,
        input  Imem2proc_valid,
        input  Imem2proc_err
    );

    modport slave (
        input  proc2Imem_req,
        input  proc2Imem_addr,
        output Imem_ready,
        output Imem2proc_data,
        output Imem2proc_valid,
        output Imem2proc_err
    );
endinterface

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
// Instruction memory that answers fetch requests after a fixed latency.
// The array is filled through the preload port while in PRELOAD; a load_done
// pulse moves to RUN, where one fetch per cycle is accepted and answered in
// order LATENCY cycles later. flush squashes responses still in flight, but
// keeps a request accepted on the same edge (the branch target).
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   bus (imem_if.slave): fetch request / response handshake
//   flush             : squash in-flight responses
//   load_en/addr/data : preload write port (usable in both states)
//   load_done         : ends the preload phase
//   fetch_count       : accepted fetches, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module imem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    imem_if.slave        bus,
    input  logic         flush,
    input  logic         load_en,
    input  logic [31:0]  load_addr,
    input  logic [31:0]  load_data,
    input  logic         load_done,
    output logic [15:0]  fetch_count
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [0:0] {
        ST_PRELOAD = 1'b0,
        ST_RUN     = 1'b1
    } state_t;

    // One in-flight response; err is only ever set together with valid.
    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } entry_t;

    logic [31:0]   mem_q [DEPTH_WORDS];
    state_t        state_q, state_d;
    logic          ready_q, ready_d;
    entry_t        pipe_q [LATENCY];
    entry_t        pipe_d [LATENCY];
    logic [31:0]   out_data_q, out_data_d;
    logic [15:0]   count_q, count_d;

    logic          accept_s;
    logic          fetch_oor_s;
    logic          load_oor_s;
    logic [AW-1:0] fetch_idx_s;
    logic [AW-1:0] load_idx_s;
    entry_t        new_entry_s;
    logic          unused_addr_bits_s;

    // Word-address decode; with a power-of-two depth any set bit above the
    // index field means the address is out of range.
    assign fetch_idx_s = bus.proc2Imem_addr[AW+1:2];
    assign load_idx_s  = load_addr[AW+1:2];
    assign fetch_oor_s = |bus.proc2Imem_addr[31:AW+2];
    assign load_oor_s  = |load_addr[31:AW+2];
    assign unused_addr_bits_s = ^{bus.proc2Imem_addr[1:0], load_addr[1:0]};

    // Preload write port; the array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (load_en && !load_oor_s) begin
            mem_q[load_idx_s] <= load_data;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_PRELOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave PRELOAD on load_done, then stay in RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PRELOAD: state_d = load_done ? ST_RUN : ST_PRELOAD;
            ST_RUN:     state_d = ST_RUN;
            default:    state_d = ST_PRELOAD;
        endcase
    end

    // FSM output: ready is registered from the next state so it rises the
    // cycle right after the load_done edge.
    always_comb begin
        ready_d = (state_d == ST_RUN);
    end

    // Build the new pipeline entry; the array read sees the pre-edge
    // contents, so a same-edge preload write yields the old word.
    always_comb begin
        accept_s    = bus.proc2Imem_req & ready_q;
        new_entry_s = '0;
        if (accept_s) begin
            new_entry_s.valid = 1'b1;
            if (fetch_oor_s) begin
                new_entry_s.err  = 1'b1;
                new_entry_s.data = NOP_WORD;
            end else begin
                new_entry_s.err  = 1'b0;
                new_entry_s.data = mem_q[fetch_idx_s];
            end
        end else begin
            new_entry_s = '0;
        end
    end

    // Pipeline advance: a flush clears every older entry, while the request
    // accepted on this edge still enters stage 0.
    always_comb begin
        pipe_d[0] = new_entry_s;
        for (int i = 1; i < LATENCY; i++) begin
            if (flush) begin
                pipe_d[i] = '0;
            end else begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
        if (pipe_d[LATENCY-1].valid) begin
            out_data_d = pipe_d[LATENCY-1].data;
        end else begin
            out_data_d = out_data_q;
        end
        if (accept_s && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Pipeline, output data, ready and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
            out_data_q <= 32'h0000_0000;
            ready_q    <= 1'b0;
            count_q    <= 16'h0000;
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            out_data_q <= out_data_d;
            ready_q    <= ready_d;
            count_q    <= count_d;
        end
    end

    // The last pipeline stage is the response register.
    assign bus.Imem_ready      = ready_q;
    assign bus.Imem2proc_data  = out_data_q;
    assign bus.Imem2proc_valid = pipe_q[LATENCY-1].valid;
    assign bus.Imem2proc_err   = pipe_q[LATENCY-1].err;
    assign fetch_count         = count_q;

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
// Directed, table-driven bench for imem_responder (DEPTH_WORDS=256,
// LATENCY=2). Each table row gives the inputs for one cycle and the outputs
// expected just after the following rising edge. A hand-written sequence
// then covers asynchronous reset with responses in flight.
// -----------------------------------------------------------------------------
module tb_imem_responder;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_done;
    logic [15:0] fetch_count;

    imem_if bus ();

    imem_responder #(
        .DEPTH_WORDS (256),
        .LATENCY     (2),
        .NOP_WORD    (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .flush       (flush),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_done   (load_done),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        flush;
        logic        ld_en;
        logic [31:0] ld_addr;
        logic [31:0] ld_data;
        logic        ld_done;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_err;
        logic        e_ready;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(logic req, logic [31:0] addr, logic fl,
                                logic ld_en, logic [31:0] ld_addr,
                                logic [31:0] ld_data, logic ld_done,
                                logic e_valid, logic [31:0] e_data,
                                logic e_err, logic e_ready, logic [15:0] e_cnt);
        vec_t v;
        v.req = req; v.addr = addr; v.flush = fl;
        v.ld_en = ld_en; v.ld_addr = ld_addr; v.ld_data = ld_data;
        v.ld_done = ld_done;
        v.e_valid = e_valid; v.e_data = e_data; v.e_err = e_err;
        v.e_ready = e_ready; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic [31:0] addr, input logic fl,
                         input logic ld_en, input logic [31:0] ld_addr,
                         input logic [31:0] ld_data, input logic ld_done);
        bus.proc2Imem_req  = req;
        bus.proc2Imem_addr = addr;
        flush              = fl;
        load_en            = ld_en;
        load_addr          = ld_addr;
        load_data          = ld_data;
        load_done          = ld_done;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic e_valid, input logic [31:0] e_data,
                           input logic e_err, input logic e_ready, input logic [15:0] e_cnt);
        chk({tag, "_valid"}, {31'd0, bus.Imem2proc_valid}, {31'd0, e_valid});
        chk({tag, "_data"},  bus.Imem2proc_data, e_data);
        chk({tag, "_err"},   {31'd0, bus.Imem2proc_err}, {31'd0, e_err});
        chk({tag, "_ready"}, {31'd0, bus.Imem_ready}, {31'd0, e_ready});
        chk({tag, "_cnt"},   {16'd0, fetch_count}, {16'd0, e_cnt});
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        //              req addr          fl ld ld_addr      ld_data       done  v  data          e  r  cnt
        // Preload phase; fetches here are ignored and the 0x400 write is dropped.
        vecs.push_back(mk(1, 32'h0000_0000, 0, 1, 32'h0000_0000, 32'h1111_1111, 0, 0, 32'h0,         0, 0, 16'd0));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 1, 32'h0000_0004, 32'h2222_2222, 0, 0, 32'h0,         0, 0, 16'd0));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 1, 32'h0000_0008, 32'h3333_3333, 0, 0, 32'h0,         0, 0, 16'd0));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 1, 32'h0000_000C, 32'h4444_4444, 0, 0, 32'h0,         0, 0, 16'd0));
        vecs.push_back(mk(1, 32'h0000_0000, 0, 1, 32'h0000_0020, 32'hDEAD_BEEF, 0, 0, 32'h0,         0, 0, 16'd0));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 1, 32'h0000_0400, 32'hBADB_AD00, 1, 0, 32'h0,         0, 1, 16'd0));
        // Back-to-back fetches 0,4,8,12: responses two edges later, no gaps.
        vecs.push_back(mk(1, 32'h0000_0000, 0, 0, 32'h0, 32'h0, 0,                   0, 32'h0,         0, 1, 16'd1));
        vecs.push_back(mk(1, 32'h0000_0004, 0, 0, 32'h0, 32'h0, 0,                   1, 32'h1111_1111, 0, 1, 16'd2));
        vecs.push_back(mk(1, 32'h0000_0008, 0, 0, 32'h0, 32'h0, 0,                   1, 32'h2222_2222, 0, 1, 16'd3));
        vecs.push_back(mk(1, 32'h0000_000C, 0, 0, 32'h0, 32'h0, 0,                   1, 32'h3333_3333, 0, 1, 16'd4));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 0, 32'h0, 32'h0, 0,                   1, 32'h4444_4444, 0, 1, 16'd4));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 0, 32'h0, 32'h0, 0,                   0, 32'h4444_4444, 0, 1, 16'd4));
        // Out-of-range fetch, then an in-range one; load_done in RUN ignored.
        vecs.push_back(mk(1, 32'h0000_0400, 0, 0, 32'h0, 32'h0, 0,                   0, 32'h4444_4444, 0, 1, 16'd5));
        vecs.push_back(mk(1, 32'h0000_0004, 0, 0, 32'h0, 32'h0, 0,                   1, 32'h0000_0013, 1, 1, 16'd6));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 0, 32'h0, 32'h0, 1,                   1, 32'h2222_2222, 0, 1, 16'd6));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 0, 32'h0, 32'h0, 0,                   0, 32'h2222_2222, 0, 1, 16'd6));
        // Fetch 0,4 then flush with a 0x20 fetch: the 0 response is already on
        // the bus when the flush edge arrives, the 4 response is squashed.
        vecs.push_back(mk(1, 32'h0000_0000, 0, 0, 32'h0, 32'h0, 0,                   0, 32'h2222_2222, 0, 1, 16'd7));
        vecs.push_back(mk(1, 32'h0000_0004, 0, 0, 32'h0, 32'h0, 0,                   1, 32'h1111_1111, 0, 1, 16'd8));
        vecs.push_back(mk(1, 32'h0000_0020, 1, 0, 32'h0, 32'h0, 0,                   0, 32'h1111_1111, 0, 1, 16'd9));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 0, 32'h0, 32'h0, 0,                   1, 32'hDEAD_BEEF, 0, 1, 16'd9));
        // Consecutive flushes, each squashing only older entries.
        vecs.push_back(mk(1, 32'h0000_0000, 0, 0, 32'h0, 32'h0, 0,                   0, 32'hDEAD_BEEF, 0, 1, 16'd10));
        vecs.push_back(mk(1, 32'h0000_0004, 1, 0, 32'h0, 32'h0, 0,                   0, 32'hDEAD_BEEF, 0, 1, 16'd11));
        vecs.push_back(mk(1, 32'h0000_0008, 1, 0, 32'h0, 32'h0, 0,                   0, 32'hDEAD_BEEF, 0, 1, 16'd12));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 0, 32'h0, 32'h0, 0,                   1, 32'h3333_3333, 0, 1, 16'd12));
        // Same-edge write and fetch of word 2: old data, then new on refetch.
        vecs.push_back(mk(1, 32'h0000_0008, 0, 1, 32'h0000_0008, 32'hCAFE_F00D, 0, 0, 32'h3333_3333, 0, 1, 16'd13));
        vecs.push_back(mk(1, 32'h0000_0008, 0, 0, 32'h0, 32'h0, 0,                   1, 32'h3333_3333, 0, 1, 16'd14));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 0, 32'h0, 32'h0, 0,                   1, 32'hCAFE_F00D, 0, 1, 16'd14));
        // Word 0 untouched by the dropped 0x400 preload; top-of-space fetch errs.
        vecs.push_back(mk(1, 32'h0000_0000, 0, 0, 32'h0, 32'h0, 0,                   0, 32'hCAFE_F00D, 0, 1, 16'd15));
        vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 32'h0, 32'h0, 0,                   1, 32'h1111_1111, 0, 1, 16'd16));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 0, 32'h0, 32'h0, 0,                   1, 32'h0000_0013, 1, 1, 16'd16));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 0, 32'h0, 32'h0, 0,                   0, 32'h0000_0013, 0, 1, 16'd16));

        // Reset state while rst is held low.
        #12;
        chk_out("reset", 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].addr, vecs[i].flush, vecs[i].ld_en,
                  vecs[i].ld_addr, vecs[i].ld_data, vecs[i].ld_done);
            tick();
            chk_out($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_data,
                    vecs[i].e_err, vecs[i].e_ready, vecs[i].e_cnt);
        end

        // Two responses in flight, then asynchronous reset between edges.
        drive(1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        chk_out("pre_rst", 1'b1, 32'h1111_1111, 1'b0, 1'b1, 16'd18);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
        #1;
        rst = 1'b1;

        // Back in PRELOAD: fetches ignored, no stale response surfaces.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            tick();
            chk_out($sformatf("post_rst%0d", k), 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk_out("rerun", 1'b0, 32'h0, 1'b0, 1'b1, 16'd0);

        // Array contents survive reset.
        drive(1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        chk_out("keep_a", 1'b0, 32'h0, 1'b0, 1'b1, 16'd1);
        drive(1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        chk_out("keep_b", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 16'd2);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        chk_out("keep_c", 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 16'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
